dmem_lsu_ctrl: RTL and testbench
================================

// Module: dmem_lsu_ctrl
// PURPOSE
//  MEM-stage load/store bus controller for the RISC-V pipeline. Turns MemReadM/MemWriteM into word-aligned
//  transactions with byte enables on a req/gnt + rvalid data-memory bus, stalls the pipeline while one is
//  outstanding and presents the raw read word to the downstream load-extract stage (byte/half select + sign ext).
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ+WAIT before abort; used only with DMEM_LSU_TIMEOUT_EN; must be >=1
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  MemReadM       in   1   load in M stage
//  MemWriteM      in   1   store in M stage
//  funct3M        in   3   RV32I load/store funct3
//  ALUResultM     in   32  effective byte address
//  WriteDataM     in   32  store data, right-justified
//  StallM         out  1   hold F..M stages; M-stage inputs are stable while high
//  MemFaultM      out  1   comb.: misaligned, illegal funct3, or MemReadM&MemWriteM
//  BusErrM        out  1   1-cycle pulse on timeout abort (0 without macro)
//  ReadData       out  32  raw aligned word of the last completed load (registered)
//  dmem_req       out  1   request valid (registered)
//  dmem_we        out  1   1=write (registered)
//  dmem_addr      out  32  {ALUResultM[31:2],2'b00} (registered)
//  dmem_be        out  4   byte enables (registered)
//  dmem_wdata     out  32  lane-replicated store data (registered)
//  dmem_gnt       in   1   request accepted this cycle
//  dmem_rvalid    in   1   load data valid this cycle
//  dmem_rdata     in   32  load data word
// BEHAVIOUR
//  Reset: state=IDLE; ReadData, dmem_*, BusErrM = 0; timeout counter = 0. Reset mid-transaction drops it silently.
//  Fault = MemRead|MemWrite and any of: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0;
//    funct3 in {011,110,111} (loads) or >3'b010 (stores); MemReadM&MemWriteM. Fault: MemFaultM=1, no bus op, StallM=0.
//  FSM (IDLE, REQ, WAIT, DONE):
//   IDLE: mem op w/o fault -> REQ, latch addr/be/wdata/we; else stay.
//   REQ : dmem_req=1, outputs held constant until dmem_gnt. gnt&store -> DONE. gnt&load&rvalid -> capture -> DONE.
//         gnt&load&!rvalid -> WAIT.
//   WAIT: dmem_req=0; on rvalid ReadData<=dmem_rdata -> DONE. gnt ignored.
//   DONE: StallM=0 for exactly one cycle (instruction leaves M) -> IDLE.
//  StallM = (IDLE & memop & !fault) | REQ | WAIT. Min latency: store 2 stall cycles, load 2 (gnt+rvalid same cycle).
//  Byte enables: loads 4'b1111. SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
//  wdata: SB {4{wd[7:0]}}; SH {2{wd[15:0]}}; SW wd.
//  ReadData changes only on load capture; holds across stores, faults and idle. rvalid outside REQ/WAIT ignored.
// CONFIGURATION
//  DMEM_LSU_TIMEOUT_EN defined: counter clears on IDLE->REQ and increments each REQ/WAIT cycle. Reaching
//    TIMEOUT_CYCLES: drop dmem_req, ReadData<=0, BusErrM=1 for one cycle, -> DONE. A late gnt/rvalid is ignored.
//  Undefined: no counter; REQ/WAIT wait forever; BusErrM tied 0.
// STRUCTURE
//  Package dmem_lsu_pkg: state enum lsu_state_t; funct3 localparams F3_B/H/W/BU/HU.
//  Sub-module dmem_store_align (comb.): funct3, addr[1:0], WriteDataM -> be, wdata.
//  Top module: FSM, request/ReadData registers, fault detect, optional watchdog.
// TESTING
//  SB addr 0x103, wd 0xAB -> dmem_be=1000, wdata=0xABABABAB, addr=0x100; gnt at 1st REQ -> StallM high 2 cycles.
//  LW 0x200, gnt delayed 3 cycles, rvalid 2 later, rdata 0xDEADBEEF -> req held stable; ReadData=0xDEADBEEF in DONE.
//  LH addr 0x201 -> MemFaultM=1, dmem_req never 1, StallM=0; ReadData unchanged.
//  Back-to-back LW 0x0 / SH 0x6 wd 0x1234 -> DONE cycle between them; SH be=1100, wdata=0x12341234.
//  reset in WAIT, then rvalid -> state IDLE, ReadData=0, rvalid ignored, StallM=0.
//  With DMEM_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never -> BusErrM pulse after 4 REQ cycles, ReadData=0.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared types for the MEM-stage load/store controller.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_store_align.sv
// Store lane alignment: byte enables and replicated write data
// from funct3, the low address bits and right-justified store data.
module dmem_store_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wd_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wd_i;
        unique case (1'b1)
            (funct3_i == F3_B): begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wd_i[7:0]}};
            end
            (funct3_i == F3_H): begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wd_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// MEM-stage load/store bus controller (req/gnt + rvalid bus).
// Optional watchdog abort enabled by defining DMEM_LSU_TIMEOUT_EN.
module dmem_lsu_ctrl
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic        MemFaultM,
    output logic        BusErrM,
    output logic [31:0] ReadData,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    lsu_state_t  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        buserr_q, buserr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [3:0]  sa_be;
    logic [31:0] sa_wdata;
    logic        memop, fault;
    logic        ld_bad, st_bad, misal;
    logic        tmo_hit;

    dmem_store_align u_align (
        .funct3_i  (funct3M),
        .addr_lo_i (ALUResultM[1:0]),
        .wd_i      (WriteDataM),
        .be_o      (sa_be),
        .wdata_o   (sa_wdata)
    );

    assign memop  = MemReadM | MemWriteM;
    assign ld_bad = (funct3M == 3'b011) | (funct3M[2:1] == 2'b11);
    assign st_bad = funct3M > F3_W;
    assign misal  = ((funct3M[1:0] == 2'b01) & ALUResultM[0])
                  | ((funct3M == F3_W) & (|ALUResultM[1:0]));
    assign fault  = memop & ((MemReadM & MemWriteM)
                  | (MemReadM & ld_bad)
                  | (MemWriteM & st_bad)
                  | misal);

`ifdef DMEM_LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE)
            cnt_d = '0;
        else if (state_q == S_REQ || state_q == S_WAIT)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Fires during the TIMEOUT_CYCLES-th REQ/WAIT cycle
    assign tmo_hit = (state_q == S_REQ || state_q == S_WAIT)
                   && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES > 0);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        buserr_d = 1'b0;
        StallM   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (memop && !fault) begin
                    StallM  = 1'b1;
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = {ALUResultM[31:2], 2'b00};
                    be_d    = MemWriteM ? sa_be : 4'b1111;
                    wdata_d = sa_wdata;
                end
            end
            S_REQ: begin
                StallM = 1'b1;
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (dmem_rvalid) begin
                        rdata_d = dmem_rdata;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (tmo_hit) begin
                    req_d    = 1'b0;
                    rdata_d  = '0;
                    buserr_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_WAIT: begin
                StallM = 1'b1;
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    rdata_d  = '0;
                    buserr_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            buserr_q <= buserr_d;
        end
    end

    assign MemFaultM  = fault;
    assign BusErrM    = buserr_q;
    assign ReadData   = rdata_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Testbench for dmem_lsu_ctrl: directed steps plus random ops
// checked against a byte-addressed reference memory model.
module tb_dmem_lsu_ctrl;

`ifdef DMEM_LSU_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM, MemFaultM, BusErrM;
    logic [31:0] ReadData;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;

    int total = 0;
    int fails = 0;

    logic [7:0]  rmem [1024];
    logic [31:0] smem [256];
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    dmem_lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .funct3M     (funct3M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .StallM      (StallM),
        .MemFaultM   (MemFaultM),
        .BusErrM     (BusErrM),
        .ReadData    (ReadData),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_fault(input logic rd, input logic wr,
                                         input logic [2:0] f3,
                                         input logic [31:0] a);
        int sz;
        if (!(rd || wr)) return 1'b0;
        if (rd && wr) return 1'b1;
        if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (wr && f3 > 2) return 1'b1;
        sz = 1 << (f3 % 4);
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a) & ~3;
        return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
    endfunction

    task automatic do_op(input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rv);
        logic        flt;
        int          sz, stalls, idx;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        longint      msk, rep;
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
        dmem_gnt   = 1'b0;
        dmem_rvalid = 1'b0;
        flt = model_fault(rd, wr, f3, a);
        @(negedge clk);
        chk("fault", MemFaultM, flt);
        if (flt) begin
            chk("stall_flt", StallM, 0);
            @(posedge clk); #1;
            MemReadM    = 1'b0;
            MemWriteM   = 1'b0;
            dmem_rvalid = 1'b1;
            dmem_rdata  = $urandom;
            @(negedge clk);
            chk("req_flt", dmem_req, 0);
            chk("rd_hold_flt", ReadData, exp_rd);
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
            return;
        end
        stalls = StallM ? 1 : 0;
        sz  = 1 << (f3 % 4);
        ebe = rd ? 4'hF : 4'((((1 << sz) - 1) << (a % 4)) & 15);
        msk = (64'd1 << (8 * sz)) - 1;
        rep = (sz == 1) ? 64'h01010101 : (sz == 2) ? 64'h00010001 : 64'd1;
        ewd = 32'((longint'(wd) & msk) * rep);
        @(posedge clk); #1;
        for (int c = 0; c <= gd; c++) begin
            dmem_gnt    = (c == gd);
            dmem_rvalid = rd && (c == gd) && (rv == 0);
            idx         = int'(dmem_addr[9:2]);
            dmem_rdata  = dmem_rvalid ? smem[idx] : $urandom;
            @(negedge clk);
            stalls += StallM ? 1 : 0;
            chk("req_hi", dmem_req, 1);
            chk("addr", dmem_addr, a & ~32'd3);
            chk("be", dmem_be, ebe);
            chk("we", dmem_we, wr);
            if (wr) chk("wdata", dmem_wdata, ewd);
            if (c == gd && wr)
                for (int j = 0; j < 4; j++)
                    if (dmem_be[j]) smem[idx][8*j +: 8] = dmem_wdata[8*j +: 8];
            @(posedge clk); #1;
        end
        for (int w = 1; rd && w <= rv; w++) begin
            dmem_gnt    = 1'($urandom_range(0, 1));
            dmem_rvalid = (w == rv);
            dmem_rdata  = dmem_rvalid ? smem[idx] : $urandom;
            @(negedge clk);
            stalls += StallM ? 1 : 0;
            chk("req_wait", dmem_req, 0);
            @(posedge clk); #1;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        if (rd) exp_rd = ref_word(a);
        if (wr)
            for (int i = 0; i < sz; i++) rmem[int'(a) + i] = wd[8*i +: 8];
        @(negedge clk);
        chk("stall_done", StallM, 0);
        chk("req_done", dmem_req, 0);
        chk("readdata", ReadData, exp_rd);
        chk("buserr", BusErrM, 0);
        chk("latency", stalls, 2 + gd + (rd ? rv : 0));
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        MemReadM    = 1'b0;
        MemWriteM   = 1'b0;
    endtask

    initial begin
        logic        r, w;
        logic [2:0]  f;
        logic [31:0] a, wv;
        int          kind;
        reset = 1'b1;
        MemReadM = 0; MemWriteM = 0; funct3M = 0;
        ALUResultM = 0; WriteDataM = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        exp_rd = 32'h0;
        for (int i = 0; i < 256; i++) begin
            wv = $urandom;
            smem[i] = wv;
            for (int j = 0; j < 4; j++) rmem[4*i + j] = wv[8*j +: 8];
        end
        #12;
        chk("rst_readdata", ReadData, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_buserr", BusErrM, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_addr", dmem_addr, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(0, 1, 3'b000, 32'h103, 32'h000000AB, 0, 0);
        do_op(1, 0, 3'b010, 32'h200, 32'h0, 3, 2);
        do_op(1, 0, 3'b001, 32'h201, 32'h0, 0, 0);
        do_op(1, 0, 3'b010, 32'h000, 32'h0, 0, 0);
        do_op(0, 1, 3'b001, 32'h006, 32'h00001234, 0, 0);
        do_op(1, 1, 3'b010, 32'h040, 32'h0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            r = (kind < 5) || (kind == 9);
            w = (kind >= 5);
            f = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << (f % 4)) - 1);
            if (a > 1016) a = 32'd1016;
            do_op(r, w, f, a, $urandom, $urandom_range(0, 3),
                  $urandom_range(0, 3));
        end

        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h40;
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        MemReadM = 1'b0;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        exp_rd = 32'h0;
        @(negedge clk);
        chk("rstw_stall", StallM, 0);
        chk("rstw_req", dmem_req, 0);
        chk("rstw_rd", ReadData, 0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstw_rv_ign", ReadData, 0);
        chk("rstw_stall2", StallM, 0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;

`ifdef DMEM_LSU_TIMEOUT_EN
        do_op(1, 0, 3'b010, 32'h80, 32'h0, 0, 0);
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h84;
        @(posedge clk); #1;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            chk("tmo_req", dmem_req, 1);
            chk("tmo_noerr", BusErrM, 0);
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h12345678;
        exp_rd = 32'h0;
        @(negedge clk);
        chk("tmo_err", BusErrM, 1);
        chk("tmo_rd", ReadData, 0);
        chk("tmo_req_lo", dmem_req, 0);
        @(posedge clk); #1;
        MemReadM = 1'b0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("tmo_pulse", BusErrM, 0);
        chk("tmo_late", ReadData, 0);
        @(posedge clk); #1;
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
